// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - ALU op codes and arbiter FSM encoding shared by alu_share_arb and alu_core
package alu_arb_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU (and/or/add/sub/signed slt), unknown op codes fall back to add
module alu_core
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  always_comb begin
    result_o = a_i + b_i;
    case (op_i)
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default: result_o = a_i + b_i;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin share of one ALU between two requesters with a one-deep result stage
// Optional saturating accept counters when ALU_ARB_STATS_EN is defined.
module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 32
`ifdef ALU_ARB_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero
`ifdef ALU_ARB_STATS_EN
  , output logic [CNT_W-1:0] stat_cnt0
  , output logic [CNT_W-1:0] stat_cnt1
`endif
);

  arb_state_t       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zero_q, rsp_zero_d;

  logic             grant0, grant1, slot_free;
  logic             accept0, accept1, accept;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic             alu_zero;

  // On a tie the requester that did not win last time gets the grant.
  assign grant0    = req0_valid & (~req1_valid | last_grant_q);
  assign grant1    = req1_valid & (~req0_valid | ~last_grant_q);
  assign slot_free = (state_q == IDLE) | rsp_ready;

  assign req0_ready = grant0 & slot_free;
  assign req1_ready = grant1 & slot_free;
  assign accept0    = req0_valid & req0_ready;
  assign accept1    = req1_valid & req1_ready;
  assign accept     = accept0 | accept1;

  assign alu_op = grant1 ? req1_op : req0_op;
  assign alu_a  = grant1 ? req1_a  : req0_a;
  assign alu_b  = grant1 ? req1_b  : req0_b;

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .op_i     (alu_op),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_zero_d   = rsp_zero_q;
    if (accept) begin
      state_d      = RESP;
      last_grant_d = accept1;
      rsp_id_d     = accept1;
      rsp_data_d   = alu_result;
      rsp_zero_d   = alu_zero;
    end else if ((state_q == RESP) && rsp_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] stat_cnt0_q, stat_cnt0_d;
  logic [CNT_W-1:0] stat_cnt1_q, stat_cnt1_d;

  // Saturate rather than wrap so a long run never reports a small count.
  always_comb begin
    stat_cnt0_d = stat_cnt0_q;
    stat_cnt1_d = stat_cnt1_q;
    if (accept0 && (stat_cnt0_q != '1)) stat_cnt0_d = stat_cnt0_q + 1'b1;
    if (accept1 && (stat_cnt1_q != '1)) stat_cnt1_d = stat_cnt1_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt0_q <= '0;
      stat_cnt1_q <= '0;
    end else begin
      stat_cnt0_q <= stat_cnt0_d;
      stat_cnt1_q <= stat_cnt1_d;
    end
  end

  assign stat_cnt0 = stat_cnt0_q;
  assign stat_cnt1 = stat_cnt1_q;
`else
  // Statistics disabled: no counter state exists in this build.
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - table-driven checks of alu_share_arb plus arbitration/backpressure/reset sequences
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op = 3'b010, req1_op = 3'b010;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp_valid, rsp_id, rsp_zero;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
`ifdef ALU_ARB_STATS_EN
  logic [3:0]  stat_cnt0, stat_cnt1;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  alu_share_arb #(
    .WIDTH(32)
`ifdef ALU_ARB_STATS_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_zero(rsp_zero)
`ifdef ALU_ARB_STATS_EN
    , .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
`endif
  );

  typedef struct {
    logic        sel;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 3'b010, 32'd5,        32'd7,        32'd12,       1'b0};
    vecs[1]  = '{1'b1, 3'b110, 32'd3,        32'd3,        32'd0,        1'b1};
    vecs[2]  = '{1'b1, 3'b000, 32'hF0,       32'h3C,       32'h30,       1'b0};
    vecs[3]  = '{1'b1, 3'b001, 32'hF0,       32'h3C,       32'hFC,       1'b0};
    vecs[4]  = '{1'b1, 3'b111, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
    vecs[5]  = '{1'b1, 3'b101, 32'd2,        32'd2,        32'd4,        1'b0};
    vecs[6]  = '{1'b0, 3'b111, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1};
    vecs[7]  = '{1'b0, 3'b010, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
    vecs[8]  = '{1'b0, 3'b110, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0};
    vecs[9]  = '{1'b0, 3'b011, 32'd3,        32'd4,        32'd7,        1'b0};
    vecs[10] = '{1'b0, 3'b111, 32'h80000000, 32'h7FFFFFFF, 32'd1,        1'b0};
    vecs[11] = '{1'b1, 3'b100, 32'd10,       32'd20,       32'd30,       1'b0};

    #2;
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_zero", {31'd0, rsp_zero}, 32'd0);
    chk("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_ready0", {31'd0, req0_ready}, 32'd0);
    chk("idle_ready1", {31'd0, req1_ready}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].sel) begin
        req1_valid = 1'b1; req1_op = vecs[i].op; req1_a = vecs[i].a; req1_b = vecs[i].b;
      end else begin
        req0_valid = 1'b1; req0_op = vecs[i].op; req0_a = vecs[i].a; req0_b = vecs[i].b;
      end
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("vec%0d_id", i), {31'd0, rsp_id}, {31'd0, vecs[i].sel});
      chk($sformatf("vec%0d_data", i), rsp_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_zero", i), {31'd0, rsp_zero}, {31'd0, vecs[i].exp_zero});
      tick();
      chk($sformatf("vec%0d_drain", i), {31'd0, rsp_valid}, 32'd0);
      chk($sformatf("vec%0d_hold", i), rsp_data, vecs[i].exp_data);
    end

    // Both requesters contend; last winner was req1 so req0 goes first.
    req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'd1; req0_b = 32'd1;
    req1_valid = 1'b1; req1_op = 3'b010; req1_a = 32'd2; req1_b = 32'd2;
    #1;
    chk("tie_ready0", {31'd0, req0_ready}, 32'd1);
    chk("tie_ready1", {31'd0, req1_ready}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rr%0d_valid", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("rr%0d_id", i), {31'd0, rsp_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("rr%0d_data", i), rsp_data, (i % 2 == 0) ? 32'd2 : 32'd4);
    end

    rsp_ready = 1'b0;
    #1;
    chk("bp_ready0", {31'd0, req0_ready}, 32'd0);
    chk("bp_ready1", {31'd0, req1_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp%0d_valid", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp%0d_id", i), {31'd0, rsp_id}, 32'd1);
      chk($sformatf("bp%0d_data", i), rsp_data, 32'd4);
      chk($sformatf("bp%0d_rdy", i), {30'd0, req1_ready, req0_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready0", {31'd0, req0_ready}, 32'd1);
    chk("bp_release_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    chk("bp_after_id", {31'd0, rsp_id}, 32'd0);
    chk("bp_after_data", rsp_data, 32'd2);

    // Asynchronous reset while a result is held, away from the clock edge.
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_data", rsp_data, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("post_rst_tie0", {31'd0, req0_ready}, 32'd1);
    chk("post_rst_tie1", {31'd0, req1_ready}, 32'd0);
    tick();
    chk("post_rst_id", {31'd0, rsp_id}, 32'd0);
    chk("post_rst_data", rsp_data, 32'd2);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

`ifdef ALU_ARB_STATS_EN
    rst_n = 1'b0;
    #1;
    chk("stat_rst0", {28'd0, stat_cnt0}, 32'd0);
    chk("stat_rst1", {28'd0, stat_cnt1}, 32'd0);
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    req0_valid = 1'b0;
    chk("stat_sat0", {28'd0, stat_cnt0}, 32'd15);
    chk("stat_idle1", {28'd0, stat_cnt1}, 32'd0);
    req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    req1_valid = 1'b0;
    tick();
    chk("stat_cnt1", {28'd0, stat_cnt1}, 32'd3);
    chk("stat_hold0", {28'd0, stat_cnt0}, 32'd15);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Shares a single ALU between two requesters (e.g. main execute path and branch-compare unit) using round-robin arbitration, valid/ready handshakes and a registered one-deep result stage. Sits between the requesters and the ALU. Takes the 3-bit ALU operation code produced by the ALU control decode. Returns one tagged response per accepted request.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- CNT_W, 16, width of statistics counters (used only with ALU_ARB_STATS_EN)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_op / req1_op  in  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- rsp_valid  out  1  result held
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester index of result
- rsp_data  out  WIDTH  result
- rsp_zero  out  1  rsp_data == 0
- stat_cnt0 / stat_cnt1  out  CNT_W  accepted-request counts (only with ALU_ARB_STATS_EN)

## Operation
- FSM states: IDLE (no result held), RESP (result held, rsp_valid=1).
- Grant: only one valid → that requester. Both valid → requester != last_grant. Neither valid → no grant.
- reqN_ready = grantN & (state==IDLE | rsp_ready). This is a combinational path from rsp_ready to req_ready.
- Accept (valid&ready): compute ALU on captured op/a/b. Register rsp_data, rsp_zero and rsp_id=N. Set last_grant=N. Go to or stay in RESP.
- RESP & rsp_ready & no accept → IDLE, rsp_valid=0. Data regs keep their last value.
- RESP & rsp_ready & accept in same cycle → stay in RESP with the new result. This gives back-to-back throughput of 1/cycle.
- RESP & !rsp_ready → all outputs held stable. Both req_ready=0.
- ALU ops:
  - add/sub wrap mod 2^WIDTH. Overflow is not reported.
  - slt is signed two's-complement; result is 1 or 0, zero-extended.
  - Undefined op codes (011,100,101) perform add.
- Requesters must hold op/a/b stable while valid & !ready. Grant may move between requesters on cycles with no handshake.
- Reset values: state=IDLE, rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_id=0, last_grant=1 (req0 wins first tie), stat counters=0.
- Reset asserted mid-transaction discards the held result. No response is issued for it.

## Timing
- Latency: accepted at edge N → rsp_valid/rsp_data valid after edge N, visible for the whole of the following cycle.
- Sustained throughput: 1 result/cycle with rsp_ready held high. Both requesters active alternate 0,1,0,1.
- Starvation bound: a continuously valid requester is accepted within 2 accept opportunities.
- All outputs are registered except req0_ready/req1_ready, which are combinational.

## Configuration
- ALU_ARB_STATS_EN defined:
  - Adds two CNT_W counters, incremented on each accept of requester 0/1 respectively.
  - Counters saturate at all-ones and are cleared only by rst_n.
  - Exposed on stat_cnt0/stat_cnt1.
- Undefined: counters and stat ports are absent. Functional behaviour is otherwise identical.

## Structure
- Package alu_arb_pkg: localparams ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_SLT=3'b111; FSM state encoding IDLE/RESP.
- Sub-module alu_core: purely combinational (op, a, b → result, zero), parameterised by WIDTH. Instantiated once, fed by the granted requester's mux.
- Arbitration, FSM, result registers and counters live in alu_share_arb.

## Test plan
- Reset then single request: req0 add 5+7, rsp_ready=1 → next cycle rsp_valid=1, rsp_id=0, rsp_data=12, rsp_zero=0.
- Ops sweep on req1: sub 3-3 → 0 with zero=1; and F0&3C → 30; or → FC; slt -1<1 → 1; op 101 with 2,2 → 4.
- Both valid continuously, rsp_ready=1 → ids 0,1,0,1 on consecutive cycles, one result per cycle.
- Backpressure: rsp_ready=0 for 3 cycles with both valid → both req_ready=0 and rsp_* stable. Raising rsp_ready accepts the next requester in the same cycle.
- Async reset asserted while rsp_valid=1 → rsp_valid=0 immediately, no stale result after release, first tie goes to req0.
- With ALU_ARB_STATS_EN, CNT_W=4: 20 accepts on req0 → stat_cnt0=15 (saturated); stat_cnt1 counts exactly req1 accepts.
